// File: rtl/bcd_time_counter.sv
// bcd_time_counter
//   Time-of-day counter producing six BCD digits (hh:mm:ss) for the alarm
//   compare stage and the display mux. A prescaler divides clk down to a
//   1 Hz advance. Each field can be set by hand, and running time is frozen
//   while set mode is active.
//
//   Build option: define TWELVE_HOUR_EN for a 12-hour clock (12,01..11) with
//   a PM flag. When it is undefined the clock counts 00..23 and pm is tied to 0.
//
// Parameters
//   CLK_HZ    system clock cycles per second (>= 2)
// Ports
//   clk       system clock, rising edge
//   rst       synchronous reset, active-high, highest priority
//   set_en    1 = set mode (timekeeping frozen, prescaler held at 0)
//   set_sel   field to set: 0 sec, 1 min, 2 hours, 3 no effect
//   inc       in set mode, +1 to the selected field on every cycle it is high
//   sec1/sec2, min1/min2, hour1/hour2   BCD tens/units digits
//   pm        PM flag (12-hour build only, otherwise 0)
//   tick_1hz  one-cycle pulse coincident with each running advance
module bcd_time_counter #(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_en,
    input  logic [1:0] set_sel,
    input  logic       inc,
    output logic [3:0] sec1,
    output logic [3:0] sec2,
    output logic [3:0] min1,
    output logic [3:0] min2,
    output logic [3:0] hour1,
    output logic [3:0] hour2,
    output logic       pm,
    output logic       tick_1hz
);

    localparam int unsigned CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_HZ - 1);

`ifdef TWELVE_HOUR_EN
    localparam logic [3:0] RST_HOUR1 = 4'd1;
    localparam logic [3:0] RST_HOUR2 = 4'd2;
`else
    localparam logic [3:0] RST_HOUR1 = 4'd0;
    localparam logic [3:0] RST_HOUR2 = 4'd0;
`endif

    logic [CW-1:0] cnt;

    // Field successors. Each one wraps inside its own field only, so the same
    // values serve both the set-mode increment and the running advance. In the
    // running case the carry between fields is applied by the sequential block.
    logic [3:0] sec1_nx, sec2_nx, min1_nx, min2_nx, hour1_nx, hour2_nx;
    logic       sec_wrap, min_wrap;
`ifdef TWELVE_HOUR_EN
    logic       hour_is_11;
`endif

    always_comb begin
        sec2_nx  = (sec2 == 4'd9) ? 4'd0 : sec2 + 4'd1;
        sec1_nx  = (sec2 == 4'd9) ? ((sec1 == 4'd5) ? 4'd0 : sec1 + 4'd1) : sec1;
        sec_wrap = (sec1 == 4'd5) && (sec2 == 4'd9);

        min2_nx  = (min2 == 4'd9) ? 4'd0 : min2 + 4'd1;
        min1_nx  = (min2 == 4'd9) ? ((min1 == 4'd5) ? 4'd0 : min1 + 4'd1) : min1;
        min_wrap = (min1 == 4'd5) && (min2 == 4'd9);

`ifdef TWELVE_HOUR_EN
        hour_is_11 = (hour1 == 4'd1) && (hour2 == 4'd1);
        if ((hour1 == 4'd1) && (hour2 == 4'd2)) begin
            hour1_nx = 4'd0;
            hour2_nx = 4'd1;
        end else if (hour2 == 4'd9) begin
            hour1_nx = hour1 + 4'd1;
            hour2_nx = 4'd0;
        end else begin
            hour1_nx = hour1;
            hour2_nx = hour2 + 4'd1;
        end
`else
        if ((hour1 == 4'd2) && (hour2 == 4'd3)) begin
            hour1_nx = 4'd0;
            hour2_nx = 4'd0;
        end else if (hour2 == 4'd9) begin
            hour1_nx = hour1 + 4'd1;
            hour2_nx = 4'd0;
        end else begin
            hour1_nx = hour1;
            hour2_nx = hour2 + 4'd1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            tick_1hz <= 1'b0;
            sec1     <= '0;
            sec2     <= '0;
            min1     <= '0;
            min2     <= '0;
            hour1    <= RST_HOUR1;
            hour2    <= RST_HOUR2;
`ifdef TWELVE_HOUR_EN
            pm       <= 1'b0;
`endif
        end else if (set_en) begin
            // Holding cnt at 0 means the first tick after release lands
            // exactly CLK_HZ cycles after set_en drops.
            cnt      <= '0;
            tick_1hz <= 1'b0;
            if (inc) begin
                case (set_sel)
                    2'd0: begin
                        sec1 <= sec1_nx;
                        sec2 <= sec2_nx;
                    end
                    2'd1: begin
                        min1 <= min1_nx;
                        min2 <= min2_nx;
                    end
                    2'd2: begin
                        hour1 <= hour1_nx;
                        hour2 <= hour2_nx;
                    end
                    default: ;
                endcase
            end
        end else if (cnt == CNT_MAX) begin
            cnt      <= '0;
            tick_1hz <= 1'b1;
            sec1     <= sec1_nx;
            sec2     <= sec2_nx;
            if (sec_wrap) begin
                min1 <= min1_nx;
                min2 <= min2_nx;
                if (min_wrap) begin
                    hour1 <= hour1_nx;
                    hour2 <= hour2_nx;
`ifdef TWELVE_HOUR_EN
                    // Only the 11 -> 12 rollover flips AM/PM.
                    if (hour_is_11)
                        pm <= ~pm;
`endif
                end
            end
        end else begin
            cnt      <= cnt + CW'(1);
            tick_1hz <= 1'b0;
        end
    end

`ifndef TWELVE_HOUR_EN
    assign pm = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed self-checking bench for bcd_time_counter with CLK_HZ = 4.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_bcd_time_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       set_en = 1'b0;
    logic [1:0] set_sel = 2'd0;
    logic       inc = 1'b0;
    logic [3:0] sec1, sec2, min1, min2, hour1, hour2;
    logic       pm;
    logic       tick_1hz;

    int unsigned total = 0;
    int unsigned bad = 0;

`ifdef TWELVE_HOUR_EN
    localparam logic [7:0] RST_H = 8'h12;
`else
    localparam logic [7:0] RST_H = 8'h00;
`endif

    logic [23:0] now_t;
    assign now_t = {hour1, hour2, min1, min2, sec1, sec2};

    bcd_time_counter #(.CLK_HZ(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .set_en   (set_en),
        .set_sel  (set_sel),
        .inc      (inc),
        .sec1     (sec1),
        .sec2     (sec2),
        .min1     (min1),
        .min2     (min2),
        .hour1    (hour1),
        .hour2    (hour2),
        .pm       (pm),
        .tick_1hz (tick_1hz)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic step(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset;
        rst = 1'b1; set_en = 1'b0; inc = 1'b0; set_sel = 2'd0;
        step(2);
        rst = 1'b0;
    endtask

    // Leaves set_en high and inc low.
    task automatic set_field(input logic [1:0] sel, input int unsigned n);
        set_en = 1'b1; set_sel = sel; inc = 1'b1;
        step(n);
        inc = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; set_en = 1'b0; inc = 1'b0;
        step(2);
        total++;
        if (now_t !== {RST_H, 16'h0000}) begin
            bad++; $display("FAIL reset_time: got %h want %h", now_t, {RST_H, 16'h0000});
        end
        total++;
        if (tick_1hz !== 1'b0 || pm !== 1'b0) begin
            bad++; $display("FAIL reset_flags: got tick=%b pm=%b want tick=0 pm=0", tick_1hz, pm);
        end
        rst = 1'b0;
        step(3);
        total++;
        if (tick_1hz !== 1'b0 || now_t !== {RST_H, 16'h0000}) begin
            bad++; $display("FAIL reset_early_tick: got tick=%b t=%h want tick=0 t=%h", tick_1hz, now_t, {RST_H, 16'h0000});
        end
        step(1);
        total++;
        if (tick_1hz !== 1'b1 || now_t !== {RST_H, 16'h0001}) begin
            bad++; $display("FAIL reset_first_tick: got tick=%b t=%h want tick=1 t=%h", tick_1hz, now_t, {RST_H, 16'h0001});
        end
    endtask

`ifndef TWELVE_HOUR_EN
    task automatic test_day_wrap;
        do_reset();
        set_field(2'd2, 23);
        set_field(2'd1, 59);
        set_field(2'd0, 59);
        total++;
        if (now_t !== 24'h235959 || tick_1hz !== 1'b0) begin
            bad++; $display("FAIL day_set: got t=%h tick=%b want t=235959 tick=0", now_t, tick_1hz);
        end
        set_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            total++;
            if (tick_1hz !== 1'b0 || now_t !== 24'h235959) begin
                bad++; $display("FAIL day_wait%0d: got t=%h tick=%b want t=235959 tick=0", i, now_t, tick_1hz);
            end
        end
        step(1);
        total++;
        if (tick_1hz !== 1'b1 || now_t !== 24'h000000) begin
            bad++; $display("FAIL day_wrap: got t=%h tick=%b want t=000000 tick=1", now_t, tick_1hz);
        end
        step(1);
        total++;
        if (tick_1hz !== 1'b0) begin
            bad++; $display("FAIL day_single_pulse: got tick=%b want 0", tick_1hz);
        end
        // set-mode hour wrap 23 -> 00
        set_field(2'd2, 23);
        set_field(2'd2, 1);
        total++;
        if ({hour1, hour2} !== 8'h00) begin
            bad++; $display("FAIL set_hour_wrap: got %h want 00", {hour1, hour2});
        end
        set_en = 1'b0;
    endtask
`endif

    task automatic test_set_minutes;
        do_reset();
        set_field(2'd2, 5);
        set_field(2'd0, 30);
        set_field(2'd1, 59);
        total++;
        if (now_t !== 24'h055930) begin
            bad++; $display("FAIL min_set: got %h want 055930", now_t);
        end
        set_field(2'd1, 1);
        total++;
        if (now_t !== 24'h050030 || tick_1hz !== 1'b0) begin
            bad++; $display("FAIL min_wrap_no_carry: got t=%h tick=%b want t=050030 tick=0", now_t, tick_1hz);
        end
        set_field(2'd3, 3);
        total++;
        if (now_t !== 24'h050030) begin
            bad++; $display("FAIL sel3_no_effect: got %h want 050030", now_t);
        end
        // set_en falls with inc high: inc must be ignored
        set_en = 1'b0; set_sel = 2'd1; inc = 1'b1;
        step(1);
        inc = 1'b0;
        total++;
        if (now_t !== 24'h050030 || tick_1hz !== 1'b0) begin
            bad++; $display("FAIL release_inc_ignored: got t=%h tick=%b want t=050030 tick=0", now_t, tick_1hz);
        end
        step(3);
        total++;
        if (now_t !== 24'h050031 || tick_1hz !== 1'b1) begin
            bad++; $display("FAIL release_tick: got t=%h tick=%b want t=050031 tick=1", now_t, tick_1hz);
        end
    endtask

    task automatic test_freeze_at_tick;
        do_reset();
        set_field(2'd0, 58);
        set_en = 1'b0;
        step(3);
        total++;
        if (now_t !== {RST_H, 16'h0058} || tick_1hz !== 1'b0) begin
            bad++; $display("FAIL freeze_pre: got t=%h tick=%b want t=%h tick=0", now_t, tick_1hz, {RST_H, 16'h0058});
        end
        set_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            total++;
            if (now_t !== {RST_H, 16'h0058} || tick_1hz !== 1'b0) begin
                bad++; $display("FAIL freeze_hold%0d: got t=%h tick=%b want t=%h tick=0", i, now_t, tick_1hz, {RST_H, 16'h0058});
            end
        end
        set_en = 1'b0;
        step(3);
        total++;
        if (now_t !== {RST_H, 16'h0058} || tick_1hz !== 1'b0) begin
            bad++; $display("FAIL freeze_release_wait: got t=%h tick=%b want t=%h tick=0", now_t, tick_1hz, {RST_H, 16'h0058});
        end
        step(1);
        total++;
        if (now_t !== {RST_H, 16'h0059} || tick_1hz !== 1'b1) begin
            bad++; $display("FAIL freeze_release_tick: got t=%h tick=%b want t=%h tick=1", now_t, tick_1hz, {RST_H, 16'h0059});
        end
        step(4);
        total++;
        if (now_t !== {RST_H, 16'h0100} || tick_1hz !== 1'b1) begin
            bad++; $display("FAIL sec_to_min_carry: got t=%h tick=%b want t=%h tick=1", now_t, tick_1hz, {RST_H, 16'h0100});
        end
    endtask

    task automatic test_rst_midcount;
        do_reset();
        set_field(2'd2, 10);
        set_field(2'd1, 20);
        set_field(2'd0, 30);
        set_en = 1'b0;
        step(2);
        total++;
        if (now_t !== 24'h102030 || tick_1hz !== 1'b0) begin
            bad++; $display("FAIL mid_pre: got t=%h tick=%b want t=102030 tick=0", now_t, tick_1hz);
        end
        rst = 1'b1;
        step(1);
        total++;
        if (now_t !== {RST_H, 16'h0000} || tick_1hz !== 1'b0 || pm !== 1'b0) begin
            bad++; $display("FAIL mid_reset: got t=%h tick=%b pm=%b want t=%h tick=0 pm=0", now_t, tick_1hz, pm, {RST_H, 16'h0000});
        end
        rst = 1'b0;
        step(3);
        total++;
        if (tick_1hz !== 1'b0) begin
            bad++; $display("FAIL mid_early_tick: got tick=%b want 0", tick_1hz);
        end
        step(1);
        total++;
        if (now_t !== {RST_H, 16'h0001} || tick_1hz !== 1'b1) begin
            bad++; $display("FAIL mid_first_tick: got t=%h tick=%b want t=%h tick=1", now_t, tick_1hz, {RST_H, 16'h0001});
        end
        // reset while in set mode
        set_field(2'd0, 5);
        rst = 1'b1;
        step(1);
        total++;
        if (now_t !== {RST_H, 16'h0000}) begin
            bad++; $display("FAIL set_mode_reset: got %h want %h", now_t, {RST_H, 16'h0000});
        end
        rst = 1'b0; set_en = 1'b0;
    endtask

    task automatic test_hour_carry;
        do_reset();
        set_field(2'd2, 9);
        set_field(2'd1, 59);
        set_field(2'd0, 59);
        set_en = 1'b0;
        step(4);
        total++;
        if (now_t !== 24'h100000 || tick_1hz !== 1'b1) begin
            bad++; $display("FAIL hour_carry: got t=%h tick=%b want t=100000 tick=1", now_t, tick_1hz);
        end
    endtask

`ifdef TWELVE_HOUR_EN
    task automatic test_twelve_hour;
        do_reset();
        set_field(2'd2, 11);
        set_field(2'd1, 59);
        set_field(2'd0, 59);
        total++;
        if (now_t !== 24'h115959 || pm !== 1'b0) begin
            bad++; $display("FAIL h12_set11: got t=%h pm=%b want t=115959 pm=0", now_t, pm);
        end
        set_en = 1'b0;
        step(4);
        total++;
        if (now_t !== 24'h120000 || pm !== 1'b1 || tick_1hz !== 1'b1) begin
            bad++; $display("FAIL h12_to_pm: got t=%h pm=%b tick=%b want t=120000 pm=1 tick=1", now_t, pm, tick_1hz);
        end
        set_field(2'd1, 59);
        set_field(2'd0, 59);
        set_en = 1'b0;
        step(4);
        total++;
        if (now_t !== 24'h010000 || pm !== 1'b1) begin
            bad++; $display("FAIL h12_12_to_01: got t=%h pm=%b want t=010000 pm=1", now_t, pm);
        end
        set_field(2'd2, 11);
        total++;
        if ({hour1, hour2} !== 8'h12) begin
            bad++; $display("FAIL h12_set_to_12: got %h want 12", {hour1, hour2});
        end
        set_field(2'd2, 1);
        total++;
        if ({hour1, hour2} !== 8'h01 || pm !== 1'b1) begin
            bad++; $display("FAIL h12_set_wrap: got h=%h pm=%b want h=01 pm=1", {hour1, hour2}, pm);
        end
        set_en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
`ifndef TWELVE_HOUR_EN
        test_day_wrap();
`endif
        test_set_minutes();
        test_freeze_at_tick();
        test_rst_midcount();
        test_hour_carry();
`ifdef TWELVE_HOUR_EN
        test_twelve_hour();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_time_counter.md
# bcd_time_counter

Time-of-day counter generating the six BCD digits (hh:mm:ss) consumed by the beeper/alarm compare stage and the display mux. Divides the system clock to a 1 Hz tick, advances seconds/minutes/hours with BCD carry, and supports a manual set mode for each field. Running time is frozen while set mode is active.

## Interface
- CLK_HZ, 100_000_000, system clock cycles per second; must be ≥ 2.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- set_en  in  1  level; 1 = set mode, with timekeeping frozen.
- set_sel  in  2  field to set: 0 = seconds, 1 = minutes, 2 = hours, 3 = reserved (no effect).
- inc  in  1  in set mode, each cycle `inc` is high increments the selected field by one.
- sec1, sec2  out  4 each  seconds tens, units (value = 10·sec1 + sec2).
- min1, min2  out  4 each  minutes tens, units.
- hour1, hour2  out  4 each  hours tens, units.
- pm  out  1  PM flag; constant 0 unless TWELVE_HOUR_EN.
- tick_1hz  out  1  one-cycle pulse, coincident with each running time advance.

## Operation
- Prescaler `cnt`, width $clog2(CLK_HZ), counts 0..CLK_HZ-1 and then wraps to 0.
- Running (set_en = 0):
  - On the edge where cnt == CLK_HZ-1: cnt ← 0, time advances one second, tick_1hz ← 1.
  - On all other edges: cnt ← cnt + 1, tick_1hz ← 0.
- Advance rules, BCD units-first:
  - sec2 wraps 9→0 and carries into sec1; sec1 wraps 5→0 and carries into minutes.
  - Minutes use the same rules as seconds and carry into hours.
  - Hours: 23 → 00 in 24-hour build; see Configuration for 12-hour build.
- Set mode (set_en = 1):
  - cnt held at 0; tick_1hz = 0; no second advance.
  - inc = 1 increments the selected field by 1 with wrap within the field only, no carry to the next field.
  - Seconds and minutes wrap 59→00. Hours wrap 23→00 (24h) or 12→01 (12h, pm unchanged).
- Leaving set mode: cnt starts from 0, so the first tick occurs CLK_HZ cycles after the first cycle with set_en = 0.
- Digits are always valid BCD: each units digit 0–9; tens of sec/min 0–5; hour1 0–2.
- Reset values:
  - cnt = 0, tick_1hz = 0, pm = 0.
  - All digits 0 (00:00:00), or 12:00:00 with pm = 0 in the 12-hour build.

## Timing
- All outputs are registered. New digits and tick_1hz become visible in the same cycle, one edge after cnt reached CLK_HZ-1.
- Tick period is exactly CLK_HZ cycles while running.
- inc latency: the field changes on the edge that samples inc = 1. No edge detection; holding inc for N cycles gives N increments.
- set_en rising on the same edge as cnt == CLK_HZ-1: set mode wins; no advance, no tick.
- set_en falling with inc = 1 on the same edge: inc is ignored (not in set mode).
- rst has priority over everything and may be asserted mid-count or in set mode. Outputs take reset values on the next edge.

## Configuration
- TWELVE_HOUR_EN defined:
  - Hours run 12, 01, 02 … 11, 12.
  - Running carry 11:59:59 → 12:00:00 toggles pm; 12:59:59 → 01:00:00 does not.
  - hour1 ∈ {0,1}.
  - Reset value 12:00:00, pm = 0.
- TWELVE_HOUR_EN undefined:
  - 24-hour count 00–23; pm tied to 0.
  - Reset value 00:00:00.

## Test plan
All scenarios use CLK_HZ = 4.
- rst high 2 cycles, then low → 00:00:00, tick_1hz = 0; first tick exactly 4 cycles later, time 00:00:01.
- Set mode: hours to 23, minutes to 59, seconds to 59; release set_en → after 4 cycles time = 00:00:00 with a single tick_1hz pulse.
- Set mode: minutes at 59, one inc with set_sel = 1 → minutes 00, hours unchanged, seconds unchanged, no tick.
- Run from 00:00:58; assert set_en on the cycle cnt == 3 → time stays 00:00:58 and tick_1hz stays 0 for the whole set window; after release, next advance exactly 4 cycles later.
- Assert rst at cnt == 2 while at 10:20:30 → next edge 00:00:00, cnt = 0; following tick 4 cycles after rst drops.
- TWELVE_HOUR_EN:
  - 11:59:59 pm = 0 → 12:00:00 pm = 1.
  - 12:59:59 pm = 1 → 01:00:00 pm = 1.
  - Set-mode inc on hours at 12 → 01, pm unchanged.
